// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, writeback.
// Drives the register bank's selects, write strobe and next_pc.
module cpu_sequencer #(
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic [4:0]  rs1_select,
  output logic [4:0]  rs2_select,
  output logic [4:0]  rd_select,
  output logic        write_enable,
  output logic [31:0] rd,
  output logic [31:0] instr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        writes_rd,
  input  logic [1:0]  wb_sel,
  input  logic        illegal,
  input  logic        halt_req,
  input  logic [31:0] alu_result,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        trap,
  output logic        halted,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instr;
  logic [31:0] r_load_data;
  logic [31:0] r_instret;
  logic        r_trap;

  logic [31:0] w_pc4;
  logic [31:0] w_raw_tgt;
  logic [31:0] w_target;
  logic        w_fetch_mis;
  logic        w_tgt_mis;
  logic        w_commit;
  logic        w_trap_set;

  assign w_pc4     = pc + 32'd4;
  assign w_raw_tgt = branch_taken ? branch_target : w_pc4;

  // Without trapping, misaligned addresses are silently word-aligned.
  assign w_target  = MISALIGN_TRAP ? w_raw_tgt
                                   : {w_raw_tgt[31:2], 2'b00};
  assign imem_addr = MISALIGN_TRAP ? pc : {pc[31:2], 2'b00};

  assign w_fetch_mis = MISALIGN_TRAP && (pc[1:0] != 2'b00);
  assign w_tgt_mis   = MISALIGN_TRAP && (w_raw_tgt[1:0] != 2'b00);

  assign instr      = r_instr;
  assign rs1_select = r_instr[19:15];
  assign rs2_select = r_instr[24:20];
  assign rd_select  = r_instr[11:7];
  assign trap       = r_trap;
  assign halted     = (r_state == S_HALT);
  assign instret    = r_instret;

  always_comb begin
    rd = alu_result;
    unique case (wb_sel)
      2'd1:    rd = r_load_data;
      2'd2:    rd = w_pc4;
      default: rd = alu_result;
    endcase
  end

  always_comb begin
    w_next       = r_state;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    write_enable = 1'b0;
    next_pc      = pc;
    w_commit     = 1'b0;
    w_trap_set   = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        if (w_fetch_mis) begin
          w_next     = S_HALT;
          w_trap_set = 1'b1;
        end else begin
          imem_req = 1'b1;
          if (imem_ready) w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          w_next     = S_HALT;
          w_trap_set = 1'b1;
        end else if (halt_req) begin
          w_next = S_HALT;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next = (is_load || is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready) w_next = S_WB;
      end
      S_WB: begin
        if (w_tgt_mis) begin
          w_next     = S_HALT;
          w_trap_set = 1'b1;
        end else begin
          write_enable = writes_rd & ~is_store;
          next_pc      = w_target;
          w_commit     = 1'b1;
          w_next       = S_FETCH;
        end
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
    // Reset dominates so nothing leaks out while the bank is resetting.
    if (rst) begin
      imem_req     = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      write_enable = 1'b0;
      next_pc      = pc;
      w_commit     = 1'b0;
      w_trap_set   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_instr     <= '0;
      r_load_data <= '0;
      r_instret   <= '0;
      r_trap      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (imem_req && imem_ready) r_instr <= imem_rdata;
      if (dmem_req && dmem_ready && is_load) r_load_data <= dmem_rdata;
      if (w_trap_set) r_trap <= 1'b1;
      if (w_commit) r_instret <= r_instret + 32'd1;
    end
  end

endmodule
